// File: rtl/sunc_upm.sv
//==============================================================================
// sunc_upm : 4-bit synchronous up counter, wraps at MAX_COUNT, async reset.
// Optional terminal-count output tc when SUNC_UPM_TC_EN is defined.
// Revision: 1.0
//==============================================================================
`default_nettype none

module sunc_upm #(
  parameter int MAX_COUNT   = 15,
  parameter int RESET_VALUE = 0
) (
  input  logic clk,
  input  logic rst,
  output logic Q0,
  output logic Q1,
  output logic Q2,
  output logic Q3
`ifdef SUNC_UPM_TC_EN
  ,
  output logic tc
`endif
);

  localparam logic [3:0] C_MAX   = MAX_COUNT[3:0];
  localparam logic [3:0] C_RESET = RESET_VALUE[3:0];

  generate
    if ((MAX_COUNT < 1) || (MAX_COUNT > 15)) begin : g_bad_max
      $error("sunc_upm: MAX_COUNT must be in 1..15");
    end
    if ((RESET_VALUE < 0) || (RESET_VALUE > MAX_COUNT)) begin : g_bad_reset
      $error("sunc_upm: RESET_VALUE must be in 0..MAX_COUNT");
    end
  endgenerate

  logic [3:0] count_q;
  logic [3:0] count_d;
  logic [3:0] w_toggle;

  // Bit i toggles once every lower bit is 1; terminal detect (or any
  // out-of-range value) overrides and clears the whole word in one edge.
  always_comb begin
    w_toggle = {count_q[2] & count_q[1] & count_q[0],
                count_q[1] & count_q[0],
                count_q[0],
                1'b1};
    count_d  = count_q ^ w_toggle;
    if (count_q >= C_MAX) begin
      count_d = 4'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= C_RESET;
    end else begin
      count_q <= count_d;
    end
  end

  assign Q0 = count_q[0];
  assign Q1 = count_q[1];
  assign Q2 = count_q[2];
  assign Q3 = count_q[3];

`ifdef SUNC_UPM_TC_EN
  assign tc = (count_q == C_MAX);
`endif

endmodule

`default_nettype wire

// File: tb/tb_sunc_upm.sv
//==============================================================================
// tb_sunc_upm : directed table-driven bench for sunc_upm (three configurations).
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_sunc_upm;

  logic clk;
  logic rst;
  logic a0, a1, a2, a3;
  logic b0, b1, b2, b3;
  logic c0, c1, c2, c3;
`ifdef SUNC_UPM_TC_EN
  logic a_tc, b_tc, c_tc;
`endif

  int tests_run;
  int tests_failed;

  // A: defaults, B: decade counter, C: MAX 12 with non-zero reset value 7
  sunc_upm dut_a (
    .clk(clk), .rst(rst), .Q0(a0), .Q1(a1), .Q2(a2), .Q3(a3)
`ifdef SUNC_UPM_TC_EN
    , .tc(a_tc)
`endif
  );

  sunc_upm #(.MAX_COUNT(9), .RESET_VALUE(0)) dut_b (
    .clk(clk), .rst(rst), .Q0(b0), .Q1(b1), .Q2(b2), .Q3(b3)
`ifdef SUNC_UPM_TC_EN
    , .tc(b_tc)
`endif
  );

  sunc_upm #(.MAX_COUNT(12), .RESET_VALUE(7)) dut_c (
    .clk(clk), .rst(rst), .Q0(c0), .Q1(c1), .Q2(c2), .Q3(c3)
`ifdef SUNC_UPM_TC_EN
    , .tc(c_tc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       rst;
    logic [3:0] exp_a;
    logic [3:0] exp_b;
    logic [3:0] exp_c;
  } vec_t;

  localparam int N_VEC = 22;
  vec_t vecs [N_VEC];

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input int ea, input int eb, input int ec);
    check({tag, " A"}, int'({a3, a2, a1, a0}), ea);
    check({tag, " B"}, int'({b3, b2, b1, b0}), eb);
    check({tag, " C"}, int'({c3, c2, c1, c0}), ec);
`ifdef SUNC_UPM_TC_EN
    check({tag, " A tc"}, int'(a_tc), int'(ea == 15));
    check({tag, " B tc"}, int'(b_tc), int'(eb == 9));
    check({tag, " C tc"}, int'(c_tc), int'(ec == 12));
`endif
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    // Free-running sequences after release: A mod 16, B mod 10, C = 7,8..12,0..
    for (int k = 1; k <= N_VEC; k++) begin
      vecs[k-1].rst   = 1'b0;
      vecs[k-1].exp_a = 4'((k) % 16);
      vecs[k-1].exp_b = 4'((k) % 10);
      vecs[k-1].exp_c = 4'((7 + k) % 13);
    end

    rst = 1'b1;
    #1;
    check_all("reset before first edge", 0, 0, 7);
    #15;
    check_all("reset held over edge", 0, 0, 7);
    #4;
    rst = 1'b0;

    for (int i = 0; i < N_VEC; i++) begin
      rst = vecs[i].rst;
      @(posedge clk);
      #1;
      check_all($sformatf("step %0d", i + 1),
                int'(vecs[i].exp_a), int'(vecs[i].exp_b), int'(vecs[i].exp_c));
      check($sformatf("step %0d B range", i + 1),
            int'({b3, b2, b1, b0} <= 4'd9), 1);
    end

    // A now at 0110: asynchronous reset pulse between edges
    #2;
    rst = 1'b1;
    #1;
    check_all("async reset mid-count", 0, 0, 7);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_all("restart after async reset", 1, 1, 8);
    @(posedge clk);
    #1;
    check_all("second count after restart", 2, 2, 9);

    // Run A up to 15 and through its wrap once more
    for (int j = 3; j <= 17; j++) begin
      @(posedge clk);
      #1;
      check_all($sformatf("run %0d", j), j % 16, j % 10, (7 + j) % 13);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
